// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store requests -> word-addressed data-memory cycles.
// Latency: load RD_LAT+1, word store 2, sub-word store RD_LAT+2 cycles accept->RespValid.
// Backpressure: o_ReqReady high only in IDLE; one idle cycle between accesses.
//
// Ports:
//   i_clk, i_rst           clock (rising edge), asynchronous active-high reset
//   i_ReqValid/o_ReqReady  request handshake; accept on edge with both high
//   i_ReqWrite, i_ReqSize, i_ReqSigned, i_ReqAddr, i_ReqWdata  request fields
//   o_RespValid            one-cycle completion pulse; o_RespRdata load result
//   o_AddrErr              misalignment flag, qualified by o_RespValid
//   o_Raddr/o_Waddr/o_Wdata/o_MemRead/o_MemWrite/i_Rdata  data-memory port
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (straight to RESP with o_AddrErr=1, no memory strobes). Without it
// the misaligned low address bits are ignored and o_AddrErr is tied 0.
module mem_access_unit #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [1:0]  i_ReqSize,
  input  logic        i_ReqSigned,
  input  logic [31:0] i_ReqAddr,
  input  logic [31:0] i_ReqWdata,
  output logic        o_RespValid,
  output logic [31:0] o_RespRdata,
  output logic        o_AddrErr,
  output logic [31:0] o_Raddr,
  output logic [31:0] o_Waddr,
  output logic [31:0] o_Wdata,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  input  logic [31:0] i_Rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [3:0] LP_RD_LAST = 4'(RD_LAT - 1);

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [31:0] r_rdword;
  logic [31:0] r_resp_rdata;
  logic [3:0]  r_cnt;

  logic        w_accept;
  logic        w_misalign;
  logic        w_rd_last;
  logic [31:0] w_shift;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_merge;

  assign w_accept  = i_ReqValid && (r_state == IDLE);
  assign w_rd_last = (r_state == RD) && (r_cnt == LP_RD_LAST);

`ifdef MISALIGN_TRAP_EN
  logic r_err;
  // Size 11 is treated as a word, so any size[1] access needs addr[1:0]==0.
  assign w_misalign = ((i_ReqSize == 2'b01) && i_ReqAddr[0]) ||
                      (i_ReqSize[1] && (i_ReqAddr[1:0] != 2'b00));
  assign o_AddrErr  = (r_state == RESP) && r_err;
`else
  assign w_misalign = 1'b0;
  assign o_AddrErr  = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and strobes
  always_comb begin
    w_next      = r_state;
    o_ReqReady  = 1'b0;
    o_MemRead   = 1'b0;
    o_MemWrite  = 1'b0;
    o_RespValid = 1'b0;
    case (r_state)
      IDLE: begin
        o_ReqReady = 1'b1;
        if (i_ReqValid) begin
          if (w_misalign)                   w_next = RESP;
          else if (i_ReqWrite && i_ReqSize[1]) w_next = WR;   // full word: no read needed
          else                              w_next = RD;
        end
      end
      RD: begin
        o_MemRead = 1'b1;
        if (r_cnt == LP_RD_LAST) w_next = r_write ? WR : RESP;
      end
      WR: begin
        o_MemWrite = 1'b1;
        w_next     = RESP;
      end
      RESP: begin
        o_RespValid = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Load path: lane select and extension straight from the memory word
  always_comb begin
    w_shift = i_Rdata >> {r_addr[1:0], 3'b000};
    w_half  = r_addr[1] ? i_Rdata[31:16] : i_Rdata[15:0];
    case (r_size)
      2'b00:   w_load_ext = {{24{r_signed & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_ext = i_Rdata;
    endcase
  end

  // Store path: sub-word stores splice the new lane into the word read back
  always_comb begin
    w_merge = r_rdword;
    case (r_size)
      2'b00: w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr       <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_rdword     <= '0;
      r_resp_rdata <= '0;
      r_cnt        <= '0;
`ifdef MISALIGN_TRAP_EN
      r_err        <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_addr   <= i_ReqAddr;
        r_size   <= i_ReqSize;
        r_signed <= i_ReqSigned;
        r_write  <= i_ReqWrite;
        r_wdata  <= i_ReqWdata;
        r_cnt    <= '0;
`ifdef MISALIGN_TRAP_EN
        r_err    <= w_misalign;
`endif
      end else if (r_state == RD) begin
        r_cnt <= w_rd_last ? 4'd0 : r_cnt + 4'd1;
      end
      // Capture on the edge that ends the last RD cycle
      if (w_rd_last) begin
        if (r_write) r_rdword     <= i_Rdata;
        else         r_resp_rdata <= w_load_ext;
      end
    end
  end

  assign o_RespRdata = r_resp_rdata;
  assign o_Raddr     = {r_addr[31:2], 2'b00};
  assign o_Waddr     = {r_addr[31:2], 2'b00};
  assign o_Wdata     = w_merge;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors against a small word memory.
// Latency: measured per access in cycles after the accept edge.
// Backpressure: requests issued only when the unit is idle; one test holds valid high.
module tb_mem_access_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        addr_err;
  logic [31:0] raddr, waddr, wdata, rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:15];

  int n_cmp = 0;
  int n_bad = 0;

  // Per-access observations
  int          lat, rd_cyc, wr_cyc, overlap;
  logic [31:0] cap_raddr, cap_waddr, cap_wdata, got_rdata;
  logic        got_err;

  always #5 clk = ~clk;

  mem_access_unit #(.RD_LAT(LAT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ReqValid(req_valid), .o_ReqReady(req_ready),
    .i_ReqWrite(req_write), .i_ReqSize(req_size), .i_ReqSigned(req_signed),
    .i_ReqAddr(req_addr), .i_ReqWdata(req_wdata),
    .o_RespValid(resp_valid), .o_RespRdata(resp_rdata), .o_AddrErr(addr_err),
    .o_Raddr(raddr), .o_Waddr(waddr), .o_Wdata(wdata),
    .o_MemRead(mem_read), .o_MemWrite(mem_write), .i_Rdata(rdata)
  );

  assign rdata = mem[raddr[5:2]];
  always @(posedge clk) if (mem_write) mem[waddr[5:2]] <= wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE, watch it to completion, return to IDLE.
  task automatic access(input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
    int n;
    bit done;
    rd_cyc = 0; wr_cyc = 0; overlap = 0; lat = 0;
    cap_raddr = '0; cap_waddr = '0; cap_wdata = '0;
    req_write = wr; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;   // scramble: the unit must use its captured copy
    req_wdata = 32'h0;
    n = 1; done = 0;
    while (!done && n < 40) begin
      if (mem_read)  begin rd_cyc++; cap_raddr = raddr; end
      if (mem_write) begin wr_cyc++; cap_waddr = waddr; cap_wdata = wdata; end
      if (mem_read && mem_write) overlap = 1;
      if (resp_valid) begin
        lat = n; got_rdata = resp_rdata; got_err = addr_err; done = 1;
      end else begin
        @(posedge clk); #1; n++;
      end
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int rdy_cnt, resp_cnt, busy_rdy;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  32'(req_ready),  32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_mread",  32'(mem_read),   32'd0);
    check("rst_mwrite", 32'(mem_write),  32'd0);
    check("rst_err",    32'(addr_err),   32'd0);
    check("rst_rdata",  resp_rdata,      32'd0);
    check("rst_raddr",  raddr,           32'd0);
    check("rst_wdata",  wdata,           32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: reset in the middle of a load (RD_LAT=3)
    req_write = 0; req_size = 2'b10; req_addr = 32'h28; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("midrd_in_rd", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    check("midrd_mread", 32'(mem_read),   32'd0);
    check("midrd_ready", 32'(req_ready),  32'd1);
    check("midrd_resp",  32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_resp", 32'(resp_valid), 32'd0);

    // 2: sw then lw
    access(1, 2'b10, 0, 32'h28, 32'hDEADBEEF);
    check("sw_lat",   32'(lat),    32'd2);
    check("sw_wrcyc", 32'(wr_cyc), 32'd1);
    check("sw_rdcyc", 32'(rd_cyc), 32'd0);
    check("sw_waddr", cap_waddr,   32'h28);
    check("sw_wdata", cap_wdata,   32'hDEADBEEF);
    check("sw_mem",   mem[10],     32'hDEADBEEF);
    access(0, 2'b10, 0, 32'h28, 32'h0);
    check("lw_lat",   32'(lat),    32'(LAT + 1));
    check("lw_rdcyc", 32'(rd_cyc), 32'(LAT));
    check("lw_raddr", cap_raddr,   32'h28);
    check("lw_data",  got_rdata,   32'hDEADBEEF);
    check("lw_err",   32'(got_err), 32'd0);

    // 3: sb into a known word (upper wdata bits must be ignored)
    access(1, 2'b10, 0, 32'h28, 32'h11223344);
    access(1, 2'b10, 0, 32'h2C, 32'h8000FF7F);
    access(1, 2'b00, 0, 32'h29, 32'hFFFFFFAB);
    check("sb_lat",    32'(lat),    32'(LAT + 2));
    check("sb_rdcyc",  32'(rd_cyc), 32'(LAT));
    check("sb_wrcyc",  32'(wr_cyc), 32'd1);
    check("sb_ovl",    32'(overlap), 32'd0);
    check("sb_raddr",  cap_raddr,   32'h28);
    check("sb_waddr",  cap_waddr,   32'h28);
    check("sb_wdata",  cap_wdata,   32'h1122AB44);
    check("sb_hold",   got_rdata,   32'hDEADBEEF);
    check("sb_mem",    mem[10],     32'h1122AB44);

    // 4: byte/half loads with extension from 0x8000FF7F
    access(0, 2'b00, 1, 32'h2C, 32'h0);
    check("lb_2c",  got_rdata, 32'h0000007F);
    access(0, 2'b00, 1, 32'h2D, 32'h0);
    check("lb_2d",  got_rdata, 32'hFFFFFFFF);
    access(0, 2'b00, 0, 32'h2D, 32'h0);
    check("lbu_2d", got_rdata, 32'h000000FF);
    access(0, 2'b01, 0, 32'h2E, 32'h0);
    check("lhu_2e", got_rdata, 32'h00008000);
    access(0, 2'b01, 1, 32'h2E, 32'h0);
    check("lh_2e",  got_rdata, 32'hFFFF8000);
    access(0, 2'b01, 1, 32'h2C, 32'h0);
    check("lh_2c",  got_rdata, 32'hFFFFFF7F);

    // sh into upper half
    access(1, 2'b01, 0, 32'h2E, 32'h12345566);
    check("sh_wdata", cap_wdata, 32'h5566FF7F);
    check("sh_lat",   32'(lat),  32'(LAT + 2));

    // 5: valid held high for 20 cycles of back-to-back loads
    rdy_cnt = 0; resp_cnt = 0; busy_rdy = 0; overlap = 0;
    req_write = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h2C; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) rdy_cnt++;
      if (resp_valid) resp_cnt++;
      if (req_ready && (mem_read || mem_write || resp_valid)) busy_rdy++;
      if (mem_read && mem_write) overlap = 1;
      @(posedge clk);
    end
    #1;
    req_valid = 1'b0;
    check("b2b_accepts", 32'(rdy_cnt),  32'd4);
    check("b2b_resps",   32'(resp_cnt), 32'd4);
    check("b2b_busyrdy", 32'(busy_rdy), 32'd0);
    check("b2b_overlap", 32'(overlap),  32'd0);
    check("b2b_data",    resp_rdata,    32'h5566FF7F);
    @(posedge clk); #1;

    // 6: misaligned word load
    access(0, 2'b10, 0, 32'h2A, 32'h0);
`ifdef MISALIGN_TRAP_EN
    check("mis_err",   32'(got_err), 32'd1);
    check("mis_lat",   32'(lat),     32'd1);
    check("mis_rdcyc", 32'(rd_cyc),  32'd0);
    check("mis_data",  got_rdata,    32'h5566FF7F);
`else
    check("mis_err",   32'(got_err), 32'd0);
    check("mis_lat",   32'(lat),     32'(LAT + 1));
    check("mis_raddr", cap_raddr,    32'h28);
    check("mis_data",  got_rdata,    32'h1122AB44);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
